// File: rtl/rr_stream_arb_4.sv
// rr_stream_arb_4 -- four-input round-robin packet arbiter feeding an external
// 4:1 data mux, with a single-entry registered output stage.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_last    per-source beat valid and end-of-packet flag
//   in_ready            per-source accept (one-hot or zero)
//   sel                 select to the external mux
//   mux_y               combinational return of the selected source's data
//   out_valid/out_data  registered beat
//   out_src/out_last    source index and last flag of the registered beat
//   out_ready           downstream accept
//
// A grant is held from the first beat of a packet through its last beat.
// sel depends only on state/ptr/in_valid, never on mux_y, so the mux return
// path closes no combinational loop.
module rr_stream_arb_4 #(
  parameter int         W       = 4,
  parameter logic [1:0] RST_PTR = 2'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [3:0]   in_last,
  output logic [3:0]   in_ready,
  output logic [1:0]   sel,
  input  logic [W-1:0] mux_y,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_src,
  output logic         out_last,
  input  logic         out_ready
);

  localparam logic [0:0] ARB    = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0] state;
  logic [1:0] ptr, lock_src, hold_sel;
  logic [1:0] winner, idx;
  logic       any_valid, gnt_en, can_load, xfer;

  assign can_load = !out_valid || out_ready;

  // Search ptr, ptr+1, ... ; walking the offsets high-to-low leaves the
  // smallest valid offset (highest priority) as the final assignment.
  always_comb begin
    winner    = ptr;
    any_valid = 1'b0;
    idx       = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (in_valid[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    sel      = hold_sel;
    gnt_en   = 1'b0;
    if (state == LOCKED) begin
      sel    = lock_src;
      gnt_en = 1'b1;
    end else if (any_valid) begin
      sel    = winner;
      gnt_en = 1'b1;
    end
    // Ready is forced low while reset is asserted so no beat is offered
    // acceptance before the block is out of reset.
    if (gnt_en && rst_n) in_ready[sel] = can_load;
  end

  assign xfer = in_valid[sel] && in_ready[sel];

  // Arbitration state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      ptr      <= RST_PTR;
      lock_src <= 2'd0;
      hold_sel <= RST_PTR;
    end else if (xfer) begin
      hold_sel <= sel;
      if (in_last[sel]) begin
        ptr   <= sel + 2'd1;
        state <= ARB;
      end else begin
        lock_src <= sel;
        state    <= LOCKED;
      end
    end
  end

  // Output stage: load may coincide with drain for full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_y;
      out_src   <= sel;
      out_last  <= in_last[sel];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_arb_4.sv
// Testbench for rr_stream_arb_4: directed phases followed by random traffic,
// checked by a packet-level round-robin reference model and an output
// scoreboard.
module tb_rr_stream_arb_4;
  localparam int W = 8;
  localparam int RP = 0;

  typedef struct {
    logic [1:0]   src;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   in_valid = '0, in_last = '0, in_ready;
  logic [1:0]   sel, out_src;
  logic [W-1:0] mux_y, out_data;
  logic         out_valid, out_last, out_ready = 1'b0;
  logic [W-1:0] src_data [4];

  int checks = 0, failures = 0;
  beat_t sb[$];

  // reference model state
  int m_ptr, m_lock, m_hold;
  bit m_occ;

  rr_stream_arb_4 #(.W(W), .RST_PTR(2'(RP))) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .sel(sel), .mux_y(mux_y), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // external 4:1 mux
  assign mux_y = src_data[sel];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr = RP; m_lock = -1; m_hold = RP; m_occ = 0;
    sb.delete();
  endfunction

  // One cycle: inputs applied just after a falling edge, expectations
  // computed from the round-robin rules, then wait for the next falling edge.
  task automatic cyc(input logic [3:0] iv, input logic [3:0] il, input logic ordy, input bit xmode);
    int g;
    bit any, can, xf;
    logic [3:0] exp_rdy;
    beat_t b;
    in_valid = iv; in_last = il; out_ready = ordy;
    for (int i = 0; i < 4; i++) src_data[i] = W'($urandom);
    if (xmode) begin
      src_data[3] = 'x;
      src_data[0] = 'x;
    end
    #1;
    any = (iv != 0);
    g = m_hold;
    if (m_lock >= 0) g = m_lock;
    else if (any)
      for (int k = 3; k >= 0; k--) if (iv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    can = !m_occ || ordy;
    exp_rdy = '0;
    if ((m_lock >= 0 || any) && can) exp_rdy[g] = 1'b1;
    chk("sel", 32'(sel), 32'(g));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    xf = exp_rdy[g] && iv[g];
    if (xf) begin
      b.src = 2'(g); b.data = src_data[g]; b.last = il[g];
      sb.push_back(b);
      m_hold = g;
      if (il[g]) begin m_ptr = (g + 1) % 4; m_lock = -1; end
      else m_lock = g;
    end
    m_occ = xf ? 1'b1 : (ordy ? 1'b0 : m_occ);
    @(negedge clk);
  endtask

  // Scoreboard monitor: a beat presented with out_ready high is consumed at
  // the next rising edge, so it is compared exactly once here.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_empty: unexpected beat src=%0d data=%h", out_src, out_data);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("out_src", 32'(out_src), 32'(e.src));
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  task automatic mid_reset();
    in_valid = 4'b1111; in_last = 4'b1111;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_sel", 32'(sel), 32'(RP));
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) src_data[i] = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_src", 32'(out_src), 32'd0);
    chk("reset_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    // round-robin over all-valid single-beat packets
    repeat (6) cyc(4'b1111, 4'b1111, 1'b1, 1'b0);
    // set ptr to 3 via a grant of src2, then wrap/skip with 0101
    cyc(4'b0100, 4'b1111, 1'b1, 1'b0);
    repeat (3) cyc(4'b0101, 4'b1111, 1'b1, 1'b0);
    // packet lock: src1 three beats with a valid gap, src2 waiting
    cyc(4'b0110, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0110, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0100, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0110, 4'b0010, 1'b1, 1'b0);
    cyc(4'b0100, 4'b0100, 1'b1, 1'b0);
    // backpressure
    cyc(4'b0001, 4'b1111, 1'b1, 1'b0);
    repeat (3) cyc(4'b1111, 4'b1111, 1'b0, 1'b0);
    repeat (2) cyc(4'b1111, 4'b1111, 1'b1, 1'b0);
    // idle hold after a src2 grant
    cyc(4'b0100, 4'b1111, 1'b1, 1'b0);
    repeat (3) cyc(4'b0000, 4'b0000, 1'b1, 1'b0);
    // unknown data on sources 0 and 3, only 3 valid
    repeat (2) cyc(4'b1000, 4'b1111, 1'b1, 1'b1);
    // random traffic with a reset dropped in mid-stream
    repeat (300) cyc(4'($urandom), 4'($urandom) & 4'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    mid_reset();
    repeat (1500) cyc(4'($urandom), 4'($urandom) & 4'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    repeat (4) cyc(4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
